// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: round-robin arbitrated write controller for a shared
// W-bit D-latch bank. Each write runs SETUP -> OPEN (C high) -> HOLD -> ACK.
// The Q readback is checked on the last OPEN cycle. All outputs are registered,
// so C cannot glitch.
module latch_write_sequencer #(
    parameter int NREQ     = 4,
    parameter int W        = 8,
    parameter int OPEN_CYC = 2,
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   ack,
    output logic [W-1:0]      D,
    output logic              C,
    input  logic [W-1:0]      Q,
    output logic              busy,
    output logic              err
);

    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CMAX = (OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_OPEN,
        S_HOLD,
        S_ACK
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     last_q, last_d;
    logic [W-1:0]      d_q, d_d;
    logic              c_q, c_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              pick_vld;
    logic [IW-1:0]     pick_idx;

    // Round-robin pick: scan from last+1 and wrap. The first request found wins.
    always_comb begin
        logic [IW-1:0] cand;
        cand     = '0;
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_q) + k) % NREQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state and registered-output values for the write sequence
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        d_d     = d_q;
        c_d     = c_q;
        gnt_d   = gnt_q;
        ack_d   = ack_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d = S_SETUP;
                    gnt_d   = NREQ'(1) << pick_idx;
                    d_d     = wdata[int'(pick_idx)*W +: W];
                    last_d  = pick_idx;
                end
            end
            S_SETUP: begin
                state_d = S_OPEN;
                c_d     = 1'b1;
                cnt_d   = CW'(OPEN_CYC - 1);
            end
            S_OPEN: begin
                if (cnt_q == '0) begin
                    // Close the latch and judge the readback on the same edge
                    state_d = S_HOLD;
                    c_d     = 1'b0;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    if (Q != d_q) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    ack_d   = gnt_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                ack_d   = '0;
                gnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                c_d     = 1'b0;
                ack_d   = '0;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers. Reset closes the latch at once and restarts the
    // arbitration pointer so that req[0] has top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= IW'(NREQ - 1);
            d_q     <= '0;
            c_q     <= 1'b0;
            gnt_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            d_q     <= d_d;
            c_q     <= c_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign D    = d_q;
    assign C    = c_q;
    assign gnt  = gnt_q;
    assign ack  = ack_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Directed bench for latch_write_sequencer. A behavioural D latch sits on D/C/Q,
// and a fault switch can force Q to zero.
module tb_latch_write_sequencer;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] wdata;
    logic [NREQ-1:0]   gnt, ack;
    logic [W-1:0]      D, Q;
    logic              C, busy, err;

    logic [W-1:0]      lat = '0;
    logic              flt = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_g = -1;

    latch_write_sequencer #(.NREQ(NREQ), .W(W), .OPEN_CYC(2), .HOLD_CYC(1)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata), .gnt(gnt), .ack(ack),
        .D(D), .C(C), .Q(Q), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural transparent latch
    always @(C or D) if (C) lat = D;
    assign Q = flt ? '0 : lat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Waits for a grant and then follows one full write, checking each phase.
    task automatic do_write(input int idx, input logic [7:0] dat, input logic [7:0] exp_q,
                            input logic exp_err, input logic chk_gap);
        int n;
        n = 0;
        while (gnt == '0 && n < 20) begin
            step();
            n++;
        end
        chk("grant_seen", 32'(n < 20), 32'd1);
        chk("gnt_idx", 32'(gnt), 32'(1) << idx);
        chk("d_capture", 32'(D), 32'(dat));
        chk("c_setup", 32'(C), 32'd0);
        chk("busy", 32'(busy), 32'd1);
        if (chk_gap) chk("grant_gap", 32'(cyc - last_g), 32'd6);
        last_g = cyc;
        step(); chk("c_open1", 32'(C), 32'd1);
        step(); chk("c_open2", 32'(C), 32'd1);
        step(); chk("c_hold", 32'(C), 32'd0);
        chk("err_after_open", 32'(err), 32'(exp_err));
        step();
        chk("ack_idx", 32'(ack), 32'(1) << idx);
        chk("gnt_in_ack", 32'(gnt), 32'(1) << idx);
        chk("q_readback", 32'(Q), 32'(exp_q));
        step();
        chk("ack_clear", 32'(ack), 32'd0);
        chk("gnt_clear", 32'(gnt), 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};

        // 1: reset holds everything idle even with all requests up
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_c", 32'(C), 32'd0);
            chk("rst_d", 32'(D), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
        end

        // 2: single write from requester 0
        req         = 4'b0001;
        wdata[7:0]  = 8'hA5;
        rst_n       = 1'b1;
        do_write(0, 8'hA5, 8'hA5, 1'b0, 1'b0);
        chk("busy_idle", 32'(busy), 32'd0);
        req        = 4'b0000;
        wdata[7:0] = 8'h11;

        // 3: round robin with all requesters held
        pulse_reset();
        req = 4'b1111;
        do_write(0, 8'h11, 8'h11, 1'b0, 1'b0);
        do_write(1, 8'h22, 8'h22, 1'b0, 1'b1);
        do_write(2, 8'h33, 8'h33, 1'b0, 1'b1);
        do_write(3, 8'h44, 8'h44, 1'b0, 1'b1);
        do_write(0, 8'h11, 8'h11, 1'b0, 1'b1);

        // 4: pointer wraps past 3 back to 0, then moves on to 2
        req = 4'b0100;
        do_write(2, 8'h33, 8'h33, 1'b0, 1'b0);
        req = 4'b0101;
        do_write(0, 8'h11, 8'h11, 1'b0, 1'b0);
        do_write(2, 8'h33, 8'h33, 1'b0, 1'b0);
        req = 4'b0000;

        // 5: readback fault sets sticky err without blocking ack
        flt         = 1'b1;
        wdata[15:8] = 8'hFF;
        req         = 4'b0010;
        do_write(1, 8'hFF, 8'h00, 1'b1, 1'b0);
        flt         = 1'b0;
        wdata[15:8] = 8'h22;
        req         = 4'b0001;
        do_write(0, 8'h11, 8'h11, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        chk("err_sticky", 32'(err), 32'd1);

        // 6: asynchronous reset during OPEN
        req = 4'b0100;
        step();
        chk("mid_gnt", 32'(gnt), 32'b0100);
        step();
        chk("mid_c_open", 32'(C), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_c", 32'(C), 32'd0);
        chk("async_d", 32'(D), 32'd0);
        chk("async_gnt", 32'(gnt), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        req = 4'b1000;
        step();
        chk("rst_no_ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        do_write(3, 8'h44, 8'h44, 1'b0, 1'b0);
        req = 4'b0000;
        step();
        chk("final_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Simulation time bound in case the stimulus ever stalls
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
